unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbitrates the single-ported unified instruction/data memory between the fetch stage (IF) and the load/store unit (LS). Grants one access at a time and drives the shared address/write-data select. Tracks the fixed memory read latency and routes the response back to the owning requester. LS has priority over IF, with a bounded-starvation override for IF.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from issue to `mem_rdata` valid (≥1)
- `STARVE_MAX`, 4, consecutive lost IF arbitrations before IF is forced (≥1)

One clock; reset is asynchronous and active-low.
- `clk` in 1 — rising-edge clock
- `rst_n` in 1 — asynchronous active-low reset
- `if_req` in 1 — fetch request, held until `if_gnt`
- `if_addr` in ADDR_W — fetch address, stable while `if_req`
- `if_gnt` out 1 — fetch accepted this cycle
- `if_rvalid` out 1 — fetch data valid
- `if_rdata` out DATA_W — fetch data
- `ls_req` in 1 — load/store request, held until `ls_gnt`
- `ls_we` in 1 — 1 = store
- `ls_be` in DATA_W/8 — store byte enables
- `ls_addr` in ADDR_W — LS address
- `ls_wdata` in DATA_W — store data
- `ls_gnt` out 1 — LS accepted this cycle
- `ls_rvalid` out 1 — load data valid / store acknowledge
- `ls_rdata` out DATA_W — load data (0 for stores)
- `addr_sel` out 1 — shared address mux select: 0 = IF, 1 = LS
- `mem_en` out 1 — memory access strobe
- `mem_we` out 1 — memory write
- `mem_be` out DATA_W/8 — memory byte enables
- `mem_addr` out ADDR_W — selected address
- `mem_wdata` out DATA_W — `ls_wdata` passthrough
- `mem_rdata` in DATA_W — memory read data, valid `MEM_LAT` cycles after `mem_en`

## Operation
- FSM states:
  - IDLE: may grant. Transitions to BUSY after a grant when `MEM_LAT` > 1; otherwise stays in IDLE.
  - BUSY: a down-counter from `MEM_LAT`-1 runs; no grants. When the counter reaches 0, returns to IDLE.
- Arbitration in IDLE:
  - If `if_req` is set and `starve_cnt` == `STARVE_MAX`, IF wins.
  - Otherwise, if `ls_req` is set, LS wins.
  - Otherwise, if `if_req` is set, IF wins.
- Grant outputs are combinational and asserted only in a granting cycle. At most one of `if_gnt`/`ls_gnt` is high per cycle.
- In the grant cycle:
  - `mem_en`=1.
  - `addr_sel` = winner.
  - `mem_we`=`ls_we`&`ls_gnt`.
  - `mem_be` = `ls_be` if LS wins, else all ones.
- `mem_we`=0 and `mem_en`=0 in every non-grant cycle.
- `addr_sel` holds its last value when not granting.
- `starve_cnt`:
  - Increments (saturating at `STARVE_MAX`) when LS wins while `if_req`=1.
  - Clears on `if_gnt` or when `if_req`=0.
- Owner tag is registered at grant and delays with the response.
- Response delivery:
  - Exactly `MEM_LAT` cycles after grant, the owner's `*_rvalid`=1 for one cycle.
  - `*_rdata`=`mem_rdata`; `ls_rdata`=0 for store acks.
  - The non-owner's rdata is 0.
- A requester dropping `req` before grant has no effect.

## Timing
- Grant at cycle T → `rvalid` at T+`MEM_LAT`. Next grant is possible at T+`MEM_LAT`, in the same cycle as `rvalid`.
- Throughput is one access per `MEM_LAT` cycles; with `MEM_LAT`=1 this is back-to-back every cycle.
- Reset values:
  - State IDLE; counter 0; `starve_cnt` 0; owner tag IF; no pending response.
  - Outputs: `if_gnt`/`ls_gnt` 0, `if_rvalid`/`ls_rvalid` 0, rdata 0, `addr_sel` 0, `mem_en`/`mem_we` 0, `mem_be` 0.
- Reset mid-access: the pending response is discarded and no `rvalid` is issued after reset release.
- Simultaneous requests while not starved: LS wins, IF waits.
- Requests in BUSY: no grant; `req` must be held.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state enum {IDLE, BUSY}
  - owner encoding OWN_IF=0 / OWN_LS=1, identical to `addr_sel` polarity
- Sub-module `mem_resp_tracker`:
  - Latency counter plus `MEM_LAT`-deep owner/valid/is-store pipeline.
  - Outputs: `busy`, `resp_valid`, `resp_owner`, `resp_is_store`.
- Top level holds arbitration, `starve_cnt` and output muxing.

## Test plan
- **Single fetch** (`MEM_LAT`=1): `if_req` with `if_addr`=0x100, `mem_rdata`=0xDEADBEEF.
  - `if_gnt`, `mem_en`=1, `addr_sel`=0 at T.
  - `if_rvalid`=1 with `if_rdata`=0xDEADBEEF at T+1; `ls_rvalid`=0.
- **Simultaneous IF+LS load** (0x200):
  - `ls_gnt` first, `addr_sel`=1.
  - `if_gnt` next free cycle.
  - Each `rvalid` routed to the correct owner.
- **Store**: `ls_we`=1, `ls_be`=0b0011, `ls_wdata`=0x12345678.
  - Grant cycle: `mem_we`=1, `mem_be`=0b0011, `mem_wdata`=0x12345678.
  - `ls_rvalid`=1 with `ls_rdata`=0 at T+`MEM_LAT`.
- **Starvation** (`STARVE_MAX`=4): `ls_req` and `if_req` held continuously.
  - Four LS grants, then one IF grant, then LS resumes.
  - `starve_cnt` reads 0 after the IF grant.
- **`MEM_LAT`=3 back-to-back loads**:
  - Grants at T, T+3, T+6.
  - `rvalid` at T+3, T+6, T+9.
  - No grant during BUSY cycles.
- **Reset mid-access**: assert `rst_n`=0 one cycle after a grant with `MEM_LAT`=3.
  - All outputs go to reset values immediately.
  - No `rvalid` after release; the next request is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: the sequencing state and
// the owner encoding. The owner encoding also serves as the address-mux select.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Owner of an access. The values match the addr_sel polarity
  // (0 = fetch address, 1 = load/store address).
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks the fixed memory read latency. A down-counter blocks new grants while
// an access is in flight. A MEM_LAT-deep pipeline carries valid/owner/is-store
// forward, so each response pops out exactly MEM_LAT cycles after its grant.
module mem_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_i,
  input  logic owner_i,
  input  logic is_store_i,
  output logic busy_o,
  output logic resp_valid_o,
  output logic resp_owner_o,
  output logic resp_is_store_o
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MEM_LAT-1:0] vld_q, own_q, st_q;

  // Next state: load MEM_LAT-1 on a grant and count down. Leave BUSY in the
  // cycle whose count reaches zero, so the next grant coincides with rvalid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue_i && (MEM_LAT > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response pipeline. Reset flushes it, so an access in flight during reset
  // never produces a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= {MEM_LAT{OWN_IF}};
      st_q  <= '0;
    end else begin
      vld_q[0] <= issue_i;
      own_q[0] <= owner_i;
      st_q[0]  <= is_store_i;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
        st_q[i]  <= st_q[i-1];
      end
    end
  end

  assign busy_o          = (state_q == BUSY);
  assign resp_valid_o    = vld_q[MEM_LAT-1];
  assign resp_owner_o    = own_q[MEM_LAT-1];
  assign resp_is_store_o = st_q[MEM_LAT-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and
// load/store (LS). LS normally wins. IF is forced through after STARVE_MAX
// consecutive losses. Responses are routed back to the requester that owned
// the access.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                addr_sel,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic            busy, resp_valid, resp_owner, resp_is_store;
  logic            if_force, grant;
  logic            addr_sel_q;
  logic [SC_W-1:0] starve_q, starve_d;

  // Arbitration: a starved IF beats LS, otherwise LS beats IF. Grants are
  // suppressed while an access is in flight and while reset is held.
  always_comb begin
    if_force = if_req && (starve_q == SC_W'(STARVE_MAX));
    if_gnt   = rst_n && !busy && if_req && (if_force || !ls_req);
    ls_gnt   = rst_n && !busy && ls_req && !if_force;
  end

  assign grant     = if_gnt | ls_gnt;
  assign addr_sel  = grant ? ls_gnt : addr_sel_q;
  assign mem_en    = grant;
  assign mem_we    = ls_gnt & ls_we;
  assign mem_be    = ls_gnt ? ls_be : (if_gnt ? {BE_W{1'b1}} : {BE_W{1'b0}});
  assign mem_addr  = (addr_sel == OWN_LS) ? ls_addr : if_addr;
  assign mem_wdata = ls_wdata;

  // Starvation count: counts LS wins over a waiting IF, saturates at the
  // threshold, and clears once IF is served or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (ls_gnt && (starve_q != SC_W'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter and the held address select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      addr_sel_q <= OWN_IF;
    end else begin
      starve_q   <= starve_d;
      addr_sel_q <= addr_sel;
    end
  end

  mem_resp_tracker #(
    .MEM_LAT(MEM_LAT)
  ) u_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_i        (grant),
    .owner_i        (ls_gnt ? OWN_LS : OWN_IF),
    .is_store_i     (mem_we),
    .busy_o         (busy),
    .resp_valid_o   (resp_valid),
    .resp_owner_o   (resp_owner),
    .resp_is_store_o(resp_is_store)
  );

  assign if_rvalid = resp_valid && (resp_owner == OWN_IF);
  assign ls_rvalid = resp_valid && (resp_owner == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !resp_is_store) ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter. Two instances (MEM_LAT=1 and MEM_LAT=3) share
// one stimulus stream. Each is compared every cycle against a timeline model
// that tracks absolute grant/response cycle numbers. Directed scenarios add
// literal expectations.
module tb_unified_mem_arbiter;

  localparam int SMAX  = 4;
  localparam int OUT_W = 11 + 4 * 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, addr_sel1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_be1;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, addr_sel3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_be3;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
    .addr_sel(addr_sel1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .addr_sel(addr_sel3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata)
  );

  logic [OUT_W-1:0] act1, act3;
  assign act1 = {if_gnt1, ls_gnt1, mem_en1, mem_we1, mem_be1, addr_sel1, if_rvalid1, ls_rvalid1,
                 mem_addr1, mem_wdata1, if_rdata1, ls_rdata1};
  assign act3 = {if_gnt3, ls_gnt3, mem_en3, mem_we3, mem_be3, addr_sel3, if_rvalid3, ls_rvalid3,
                 mem_addr3, mem_wdata3, if_rdata3, ls_rdata3};

  // Timeline model state, one slot per instance.
  int   cyc = 0;
  int   nextFree [2];
  int   respAt   [2];
  int   starve   [2];
  logic respOwn  [2];
  logic respSt   [2];
  logic aSel     [2];

  // Each falling edge: derive every output from the current inputs and the
  // model timeline, compare both instances, then advance the model one cycle.
  always @(negedge clk) begin : model_cmp
    int lat;
    logic can, frc, eIf, eLs, sel, rv;
    logic [3:0] eBe;
    logic [OUT_W-1:0] expV, actV;
    for (int k = 0; k < 2; k++) begin
      lat  = (k == 0) ? 1 : 3;
      actV = (k == 0) ? act1 : act3;
      if (!rst_n) begin
        expV = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, if_addr, ls_wdata, 32'h0, 32'h0};
        nextFree[k] = 0;
        respAt[k]   = -1;
        starve[k]   = 0;
        respOwn[k]  = 1'b0;
        respSt[k]   = 1'b0;
        aSel[k]     = 1'b0;
      end else begin
        can = (cyc >= nextFree[k]);
        frc = if_req && (starve[k] == SMAX);
        eIf = can && if_req && (frc || !ls_req);
        eLs = can && ls_req && !frc;
        sel = eLs ? 1'b1 : (eIf ? 1'b0 : aSel[k]);
        eBe = eLs ? ls_be : (eIf ? 4'hF : 4'h0);
        rv  = (respAt[k] == cyc);
        expV = {eIf, eLs, eIf | eLs, eLs & ls_we, eBe, sel, rv & !respOwn[k], rv & respOwn[k],
                sel ? ls_addr : if_addr, ls_wdata,
                (rv && !respOwn[k]) ? mem_rdata : 32'h0,
                (rv && respOwn[k] && !respSt[k]) ? mem_rdata : 32'h0};
        if (eIf || eLs) begin
          nextFree[k] = cyc + lat;
          respAt[k]   = cyc + lat;
          respOwn[k]  = eLs;
          respSt[k]   = eLs && ls_we;
          aSel[k]     = sel;
        end
        if (eIf || !if_req) starve[k] = 0;
        else if (eLs && starve[k] < SMAX) starve[k] = starve[k] + 1;
      end
      assertCount++;
      if (actV !== expV) begin
        failCount++;
        $display("[TB] FAIL model_cmp lat%0d cycle %0d: got %h expected %h", lat, cyc, actV, expV);
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic applyStimulus(input logic r, input logic ifr, input logic [31:0] ifa,
                               input logic lsr, input logic we, input logic [3:0] be,
                               input logic [31:0] la, input logic [31:0] wd, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst_n     = r;
    if_req    = ifr;
    if_addr   = ifa;
    ls_req    = lsr;
    ls_we     = we;
    ls_be     = be;
    ls_addr   = la;
    ls_wdata  = wd;
    mem_rdata = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    // Reset state
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("reset_mem_en", mem_en1, 1'b0);
    checkBit("reset_addr_sel", addr_sel3, 1'b0);
    checkOutput("reset_mem_be", {28'b0, mem_be3}, 32'h0);
    idle(2);

    // Single fetch, MEM_LAT=1
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("fetch_if_gnt", if_gnt1, 1'b1);
    checkBit("fetch_mem_en", mem_en1, 1'b1);
    checkBit("fetch_addr_sel", addr_sel1, 1'b0);
    checkOutput("fetch_mem_addr", mem_addr1, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    checkBit("fetch_if_rvalid", if_rvalid1, 1'b1);
    checkOutput("fetch_if_rdata", if_rdata1, 32'hDEADBEEF);
    checkBit("fetch_ls_rvalid", ls_rvalid1, 1'b0);
    idle(4);

    // Simultaneous IF + LS load
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("simul_ls_gnt", ls_gnt1, 1'b1);
    checkBit("simul_if_wait", if_gnt1, 1'b0);
    checkBit("simul_addr_sel", addr_sel1, 1'b1);
    checkOutput("simul_mem_addr", mem_addr1, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hA5A50001);
    @(negedge clk);
    checkBit("simul_if_gnt", if_gnt1, 1'b1);
    checkBit("simul_ls_rvalid", ls_rvalid1, 1'b1);
    checkOutput("simul_ls_rdata", ls_rdata1, 32'hA5A50001);
    checkBit("simul_if_rvalid_early", if_rvalid1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D);
    @(negedge clk);
    checkBit("simul_if_rvalid", if_rvalid1, 1'b1);
    checkOutput("simul_if_rdata", if_rdata1, 32'h0BADF00D);
    idle(4);

    // Store
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h300, 32'h12345678, 32'h0);
    @(negedge clk);
    checkBit("store_ls_gnt", ls_gnt1, 1'b1);
    checkBit("store_mem_we", mem_we1, 1'b1);
    checkOutput("store_mem_be", {28'b0, mem_be1}, 32'h3);
    checkOutput("store_mem_wdata", mem_wdata1, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D);
    @(negedge clk);
    checkBit("store_ack", ls_rvalid1, 1'b1);
    checkOutput("store_ls_rdata", ls_rdata1, 32'h0);
    checkBit("store_addr_sel_hold", addr_sel1, 1'b1);
    checkBit("store_mem_we_off", mem_we1, 1'b0);
    idle(4);

    // Starvation: four LS wins, one forced IF, then LS again
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 4'hF, 32'h208, 32'h0, 32'h0);
      @(negedge clk);
      checkBit($sformatf("starve_ls_gnt_%0d", i), ls_gnt1, (i != 4));
      checkBit($sformatf("starve_if_gnt_%0d", i), if_gnt1, (i == 4));
      if (i == 4) checkOutput("starve_cnt_full", {29'b0, dut1.starve_q}, 32'd4);
      if (i == 5) checkOutput("starve_cnt_cleared", {29'b0, dut1.starve_q}, 32'd0);
    end
    idle(4);

    // MEM_LAT=3 back-to-back loads
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, (i < 7), 1'b0, 4'hF, 32'h210, 32'h0, 32'h5000 + 32'(i));
      @(negedge clk);
      checkBit($sformatf("lat3_ls_gnt_%0d", i), ls_gnt3, (i < 7) && (i % 3 == 0));
      checkBit($sformatf("lat3_ls_rvalid_%0d", i), ls_rvalid3, (i != 0) && (i % 3 == 0));
      checkOutput($sformatf("lat3_ls_rdata_%0d", i), ls_rdata3,
                  ((i != 0) && (i % 3 == 0)) ? 32'h5000 + 32'(i) : 32'h0);
    end
    idle(2);

    // Reset one cycle after a MEM_LAT=3 grant
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("rst_pre_if_gnt", if_gnt3, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("rst_mem_en", mem_en3, 1'b0);
    checkBit("rst_if_rvalid", if_rvalid3, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFF0000);
      @(negedge clk);
      checkBit($sformatf("rst_no_rvalid_%0d", i), if_rvalid3, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkBit("rst_post_if_gnt", if_gnt3, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h77);
      @(negedge clk);
      checkBit($sformatf("rst_post_rvalid_%0d", j), if_rvalid3, (j == 3));
    end

    // Randomized traffic with occasional reset pulses
    repeat (400) begin
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), $urandom,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    $urandom, $urandom, $urandom);
    end
    idle(5);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
